// File: rtl/pulse_meter.sv
// Pulse high-time meter: synchronises `signal`, measures each pulse in clocks and
// offers the result on a one-entry valid/ready slot. Optional glitch filter: PULSE_METER_MIN_FILTER_EN.
module pulse_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH_BITS  = 8,
    parameter int COUNT_BITS  = 8,
    parameter int MIN_WIDTH   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  signal,
    input  logic                  enable,
    output logic [WIDTH_BITS-1:0] width,
    output logic                  width_valid,
    input  logic                  width_ready,
    output logic                  saturated,
    output logic [COUNT_BITS-1:0] pulse_count,
    output logic                  dropped
);

    typedef enum logic {S_IDLE, S_HIGH} state_t;

    state_t                r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_prime;
    logic                  r_s_d;
    logic                  r_armed;
    logic [WIDTH_BITS-1:0] r_run, w_run_nxt;
    logic                  r_sat, w_sat_nxt;
    logic [WIDTH_BITS-1:0] r_width;
    logic                  r_valid;
    logic                  r_sat_o;
    logic [COUNT_BITS-1:0] r_count;
    logic                  r_dropped;

    logic w_s, w_rise, w_fall, w_done, w_accept, w_free;

    assign w_s    = r_sync[SYNC_STAGES-1];
    // Rises are only trusted once the synchroniser has flushed and the line has been seen low,
    // so a pulse already high at reset release is not measured.
    assign w_rise = w_s & ~r_s_d & r_armed;
    assign w_fall = ~w_s & r_s_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_prime <= '0;
            r_s_d   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], signal};
            r_prime <= {r_prime[SYNC_STAGES-2:0], 1'b1};
            r_s_d   <= w_s;
            r_armed <= r_armed | (r_prime[SYNC_STAGES-1] & ~w_s);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_run   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_sat_nxt   = r_sat;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise && enable) begin
                    w_state_nxt = S_HIGH;
                    w_run_nxt   = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
                    w_sat_nxt   = 1'b0;
                end
            end
            S_HIGH: begin
                // Losing enable wins over a coincident fall: the pulse is abandoned unreported.
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fall) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else if (w_s) begin
                    if (&r_run) w_sat_nxt = 1'b1;
                    else        w_run_nxt = r_run + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef PULSE_METER_MIN_FILTER_EN
    assign w_accept = w_done && (r_run >= WIDTH_BITS'(MIN_WIDTH));
`else
    assign w_accept = w_done;
`endif

    assign w_free = ~r_valid | width_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_width   <= '0;
            r_valid   <= 1'b0;
            r_sat_o   <= 1'b0;
            r_count   <= '0;
            r_dropped <= 1'b0;
        end else begin
            if (w_accept && w_free) begin
                r_width <= r_run;
                r_sat_o <= r_sat;
                r_valid <= 1'b1;
            end else if (r_valid && width_ready) begin
                r_valid <= 1'b0;
            end
            r_dropped <= w_accept & ~w_free;
            if (w_accept) r_count <= r_count + 1'b1;
        end
    end

    assign width       = r_width;
    assign width_valid = r_valid;
    assign saturated   = r_sat_o;
    assign pulse_count = r_count;
    assign dropped     = r_dropped;

endmodule
